// File: rtl/hapb_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write master (AW/W/B) among NUM_REQ push requesters.
// Only one single-beat write is outstanding at a time; B is routed back to the granted requester.
module hapb_wr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                       axi4_mm_clk,
   input  logic                       axi4_mm_rst,
   input  logic [NUM_REQ*12-1:0]      s_awid,
   input  logic [NUM_REQ*64-1:0]      s_awaddr,
   input  logic [NUM_REQ*6-1:0]       s_awuser,
   input  logic [NUM_REQ-1:0]         s_awvalid,
   output logic [NUM_REQ-1:0]         s_awready,
   input  logic [NUM_REQ*512-1:0]     s_wdata,
   input  logic [NUM_REQ*64-1:0]      s_wstrb,
   input  logic [NUM_REQ-1:0]         s_wlast,
   input  logic [NUM_REQ-1:0]         s_wvalid,
   output logic [NUM_REQ-1:0]         s_wready,
   output logic [NUM_REQ*2-1:0]       s_bresp,
   output logic [NUM_REQ-1:0]         s_bvalid,
   input  logic [NUM_REQ-1:0]         s_bready,
   output logic [11:0]                m_awid,
   output logic [63:0]                m_awaddr,
   output logic [5:0]                 m_awuser,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [511:0]               m_wdata,
   output logic [63:0]                m_wstrb,
   output logic                       m_wlast,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic [11:0]                m_bid,
   input  logic [1:0]                 m_bresp,
   input  logic [3:0]                 m_buser,
   input  logic                       m_bvalid,
   output logic                       m_bready,
   output logic [IDX_W-1:0]           grant_idx,
   output logic                       busy,
   output logic [NUM_REQ*CNT_W-1:0]   done_cnt
);

   typedef enum logic [1:0] {StIdle, StAddrData, StResp} state_e;

   state_e             state_q, state_d;
   logic               aw_done_q, aw_done_d;
   logic               w_done_q, w_done_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]   cnt_q [NUM_REQ];
   logic [CNT_W-1:0]   cnt_d [NUM_REQ];

   logic [NUM_REQ-1:0] sel;
   logic               g_awvalid, g_wvalid, g_bready;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               unused_b;

   assign unused_b  = ^{m_bid, m_buser};
   assign grant_idx = grant_q;
   assign busy      = (state_q != StIdle);

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      assign done_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
   end

   // Payloads are muxed from the granted requester at all times; only the valids are gated.
   always_comb begin
      sel       = '0;
      m_awid    = '0;
      m_awaddr  = '0;
      m_awuser  = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = 1'b0;
      g_awvalid = 1'b0;
      g_wvalid  = 1'b0;
      g_bready  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q == IDX_W'(i)) begin
            sel[i]    = 1'b1;
            m_awid    = s_awid[i*12 +: 12];
            m_awaddr  = s_awaddr[i*64 +: 64];
            m_awuser  = s_awuser[i*6 +: 6];
            m_wdata   = s_wdata[i*512 +: 512];
            m_wstrb   = s_wstrb[i*64 +: 64];
            m_wlast   = s_wlast[i];
            g_awvalid = s_awvalid[i];
            g_wvalid  = s_wvalid[i];
            g_bready  = s_bready[i];
         end
      end
   end

   // Round-robin: first pending index above last_grant, else wrap to the lowest pending index.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = last_grant_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!pick_valid && s_awvalid[i] && (32'(last_grant_q) < i)) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!pick_valid && s_awvalid[i] && (i <= 32'(last_grant_q))) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      m_awvalid    = 1'b0;
      m_wvalid     = 1'b0;
      m_bready     = 1'b0;
      s_awready    = '0;
      s_wready     = '0;
      s_bvalid     = '0;
      s_bresp      = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = StAddrData;
            end
         end
         StAddrData: begin
            m_awvalid = g_awvalid & ~aw_done_q;
            m_wvalid  = g_wvalid & ~w_done_q;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               s_awready[i] = sel[i] & m_awready & ~aw_done_q;
               s_wready[i]  = sel[i] & m_wready & ~w_done_q;
            end
            aw_done_d = aw_done_q | (m_awvalid & m_awready);
            w_done_d  = w_done_q | (m_wvalid & m_wready);
            if (aw_done_d && w_done_d) begin
               state_d = StResp;
            end
         end
         StResp: begin
            m_bready = g_bready;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               s_bvalid[i]         = sel[i] & m_bvalid;
               s_bresp[i*2 +: 2]   = sel[i] ? m_bresp : 2'b00;
               if (sel[i] && m_bvalid && g_bready) begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            if (m_bvalid && g_bready) begin
               last_grant_d = grant_q;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axi4_mm_clk) begin
      if (axi4_mm_rst) begin
         state_q      <= StIdle;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         grant_q      <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hapb_wr_arbiter.sv
// Directed bench for hapb_wr_arbiter: bench acts as requesters and AXI slave,
// with a scoreboard queue of issued writes popped at each granted master transfer.
module tb_hapb_wr_arbiter;
   localparam int NR = 2;
   localparam int CW = 4;
   localparam int IW = 1;

   logic clk = 1'b0;
   logic rst;
   logic [NR*12-1:0]  s_awid;
   logic [NR*64-1:0]  s_awaddr;
   logic [NR*6-1:0]   s_awuser;
   logic [NR-1:0]     s_awvalid, s_awready;
   logic [NR*512-1:0] s_wdata;
   logic [NR*64-1:0]  s_wstrb;
   logic [NR-1:0]     s_wlast, s_wvalid, s_wready;
   logic [NR*2-1:0]   s_bresp;
   logic [NR-1:0]     s_bvalid, s_bready;
   logic [11:0]       m_awid;
   logic [63:0]       m_awaddr;
   logic [5:0]        m_awuser;
   logic              m_awvalid, m_awready;
   logic [511:0]      m_wdata;
   logic [63:0]       m_wstrb;
   logic              m_wlast, m_wvalid, m_wready;
   logic [11:0]       m_bid;
   logic [1:0]        m_bresp;
   logic [3:0]        m_buser;
   logic              m_bvalid, m_bready;
   logic [IW-1:0]     grant_idx;
   logic              busy;
   logic [NR*CW-1:0]  done_cnt;

   hapb_wr_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .CNT_W(CW)) dut (
      .axi4_mm_clk(clk), .axi4_mm_rst(rst),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awuser(s_awuser),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awuser(m_awuser),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .grant_idx(grant_idx), .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           req;
      logic [11:0]  id;
      logic [63:0]  addr;
      logic [5:0]   user;
      logic [511:0] data;
      logic [63:0]  strb;
   } txn_t;

   txn_t     exp_q[$];
   txn_t     cur;
   int       grant_log[$];
   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   int       issue_cyc, last_g, cur_g, outstanding;
   bit       in_txn, aw_seen, w_seen, chk_lat, w_first;
   int       rem[NR], seq[NR], bvcyc[NR];
   logic [CW-1:0] exp_cnt[NR];
   logic [63:0]   base[NR];
   int       aw_stall, bready_stall;
   bit       w_hold;
   logic [1:0] b_resp_val;

   task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (last_g + k) % NR;
         if (s_awvalid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic issue(int i);
      txn_t t;
      t.req  = i;
      t.addr = base[i] + 64'(seq[i]) * 64;
      t.id   = 12'(i * 256 + seq[i]);
      t.user = 6'(seq[i] + i);
      t.data = {8{t.addr ^ 64'hA5A5_0000_0000_0000}};
      t.strb = {t.addr[31:0], ~t.addr[31:0]};
      seq[i]++;
      s_awid[i*12 +: 12]     = t.id;
      s_awaddr[i*64 +: 64]   = t.addr;
      s_awuser[i*6 +: 6]     = t.user;
      s_wdata[i*512 +: 512]  = t.data;
      s_wstrb[i*64 +: 64]    = t.strb;
      s_wlast[i]  = 1'b1;
      s_awvalid[i] = 1'b1;
      s_wvalid[i]  = 1'b1;
      issue_cyc = cyc;
      exp_q.push_back(t);
   endtask

   task automatic clear_model();
      exp_q.delete();
      in_txn = 0; aw_seen = 0; w_seen = 0; outstanding = 0;
      last_g = NR - 1;
      aw_stall = 0; bready_stall = 0; w_hold = 0; chk_lat = 0;
      for (int i = 0; i < NR; i++) begin
         exp_cnt[i] = '0; rem[i] = 0; bvcyc[i] = 0;
      end
   endtask

   // One clock: observe at negedge, react from the requester/slave side just after posedge.
   task automatic tick();
      bit aw_hs, w_hs, b_hs;
      logic [NR-1:0] saw, sw, sb;
      int fidx, aidx;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("done_cnt%0d", i), done_cnt[i*CW +: CW], exp_cnt[i]);
         if (s_bvalid[i]) bvcyc[i]++;
      end
      if (in_txn && w_seen) check("w_closed", {m_wvalid, s_wready}, 0);
      if (in_txn && aw_seen) check("aw_closed", {m_awvalid, s_awready}, 0);
      if (m_bvalid && aw_seen && w_seen && !s_bready[cur_g]) begin
         check("b_backpressure_bready", m_bready, 0);
         check("b_backpressure_busy", busy, 1);
      end
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      saw = s_awvalid & s_awready;
      sw  = s_wvalid & s_wready;
      sb  = s_bvalid & s_bready;
      if ((aw_hs || w_hs) && !in_txn) begin
         cur_g = pick();
         in_txn = 1;
         check("pick_pending", cur_g >= 0, 1);
         fidx = -1;
         for (int k = 0; k < exp_q.size(); k++)
            if (fidx < 0 && exp_q[k].req == cur_g) fidx = k;
         check("sb_entry_found", fidx >= 0, 1);
         if (fidx >= 0) begin
            cur = exp_q[fidx];
            exp_q.delete(fidx);
         end
         check("grant_idx", grant_idx, cur_g);
      end
      if (aw_hs) begin
         check("aw_one_outstanding", outstanding, 0);
         check("aw_ready_onehot", s_awready, 1 << cur_g);
         check("awaddr", m_awaddr, cur.addr);
         check("awid", m_awid, cur.id);
         check("awuser", m_awuser, cur.user);
         if (chk_lat) check("aw_latency", cyc - issue_cyc + 1, 2);
         aidx = -1;
         for (int i = 0; i < NR; i++) if (s_awready[i]) aidx = i;
         grant_log.push_back(aidx);
         w_first = w_seen;
         outstanding++;
         aw_seen = 1;
      end
      if (w_hs) begin
         check("w_single_beat", w_seen, 0);
         check("w_ready_onehot", s_wready, 1 << cur_g);
         check("wdata", m_wdata, cur.data);
         check("wstrb", m_wstrb, cur.strb);
         check("wlast", m_wlast, 1);
         w_seen = 1;
      end
      if (b_hs) begin
         check("b_after_aw_w", {aw_seen, w_seen}, 2'b11);
         check("s_bvalid_route", s_bvalid, 1 << cur_g);
         check("s_bresp_route", s_bresp[cur_g*2 +: 2], b_resp_val);
         exp_cnt[cur_g]++;
         outstanding--;
         last_g = cur_g;
         in_txn = 0; aw_seen = 0; w_seen = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++) begin
         if (saw[i]) s_awvalid[i] = 1'b0;
         if (sw[i]) s_wvalid[i] = 1'b0;
         if (sb[i] && rem[i] > 0) begin
            rem[i]--;
            issue(i);
         end
      end
      m_bvalid = aw_seen && w_seen;
      m_bresp  = b_resp_val;
      if (aw_stall > 0) begin
         m_awready = 1'b0;
         aw_stall--;
      end else begin
         m_awready = 1'b1;
      end
      m_wready = !w_hold;
      if (bready_stall > 0) begin
         s_bready = '0;
         if (m_bvalid) bready_stall--;
      end else begin
         s_bready = '1;
      end
   endtask

   task automatic run(int budget);
      int n = 0;
      while ((s_awvalid != 0 || in_txn || rem[0] != 0 || rem[1] != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain", {s_awvalid != 0, in_txn}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_awvalid = '0; s_wvalid = '0; s_bready = '1;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
      clear_model();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      s_awid = '0; s_awaddr = '0; s_awuser = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
      m_bid = '0; m_buser = '0; m_bresp = '0; b_resp_val = 2'b00;
      for (int i = 0; i < NR; i++) begin
         seq[i] = 0;
         base[i] = 64'h2000_0000 + 64'(i) * 64'h1_0000;
      end
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_grant_idx", grant_idx, 0);
      check("rst_done_cnt", done_cnt, 0);
      check("rst_valids", {m_awvalid, m_wvalid, m_bready}, 0);
      check("rst_readies", {s_awready, s_wready, s_bvalid}, 0);
      @(posedge clk); #1;

      // Single request from requester 1
      base[1] = 64'h1000_0000;
      chk_lat = 1;
      issue(1);
      run(40);
      chk_lat = 0;
      check("single_bpulse1", bvcyc[1], 1);
      check("single_bpulse0", bvcyc[0], 0);
      check("single_cnt1", done_cnt[1*CW +: CW], 1);
      check("single_cnt0", done_cnt[0 +: CW], 0);
      check("single_idle", busy, 0);

      // Round-robin: six back-to-back writes each
      grant_log.delete();
      rem[0] = 5; rem[1] = 5;
      issue(0); issue(1);
      run(200);
      check("rr_count", grant_log.size(), 12);
      for (int k = 0; k < 12 && k < grant_log.size(); k++)
         check($sformatf("rr_order%0d", k), grant_log[k], k % 2);
      check("rr_cnt0", done_cnt[0 +: CW], 6);
      check("rr_cnt1", done_cnt[1*CW +: CW], 7);

      // Split handshakes: W accepted while AW is stalled
      aw_stall = 3;
      m_awready = 1'b0;
      issue(0);
      run(40);
      check("split_w_first", w_first, 1);
      check("split_cnt0", done_cnt[0 +: CW], 7);

      // B backpressure from requester 1, SLVERR routed back
      b_resp_val = 2'b10;
      bready_stall = 4;
      s_bready = '0;
      issue(1);
      run(40);
      check("bp_cnt1", done_cnt[1*CW +: CW], 8);
      b_resp_val = 2'b00;

      // Reset in ADDR_DATA after the AW handshake
      w_hold = 1;
      m_wready = 1'b0;
      issue(1);
      for (int n = 0; n < 20 && !aw_seen; n++) tick();
      check("midrst_aw_done", aw_seen, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_bvalid = 1'b1;
      m_wready = 1'b1;
      @(negedge clk);
      check("midrst_mvalids", {m_awvalid, m_wvalid}, 0);
      check("midrst_sreadies", {s_awready, s_wready, s_bvalid}, 0);
      check("midrst_late_b", m_bready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt", done_cnt, 0);
      check("midrst_grant", grant_idx, 0);
      @(posedge clk); #1;
      m_bvalid = 1'b0;
      s_awvalid = '0; s_wvalid = '0;
      clear_model();
      grant_log.delete();
      issue(1); issue(0);
      run(40);
      check("midrst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      check("midrst_cnts", done_cnt, {4'd1, 4'd1});

      // Counter wrap with 4-bit counters: 17 writes from requester 0
      do_reset();
      rem[0] = 16;
      issue(0);
      run(200);
      check("wrap_cnt0", done_cnt[0 +: CW], 1);
      check("wrap_cnt1", done_cnt[1*CW +: CW], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hapb_wr_arbiter.md
Name: hapb_wr_arbiter

Overview:
Shares one AXI4 write master port (AW/W/B) between NUM_REQ hot-address pushing requesters, e.g. one pusher per memory channel. Arbitration is round-robin with exactly one outstanding single-beat write system-wide. The B response is routed back to the granted requester. The block sits between the per-channel push engines and the shared host-write AXI port, and keeps per-requester completion counters for software status.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ) (min 1), width of grant index
CNT_W, 32, width of per-requester completion counters

Ports:
axi4_mm_clk  in  1  clock
axi4_mm_rst  in  1  synchronous reset, active-high
s_awid  in  NUM_REQ*12  per-requester AWID, requester i at [i*12 +: 12]
s_awaddr  in  NUM_REQ*64  per-requester byte address
s_awuser  in  NUM_REQ*6  per-requester AWUSER
s_awvalid  in  NUM_REQ  per-requester AW valid
s_awready  out  NUM_REQ  per-requester AW ready
s_wdata  in  NUM_REQ*512  per-requester write data
s_wstrb  in  NUM_REQ*64  per-requester strobes
s_wlast  in  NUM_REQ  per-requester WLAST (always 1, single beat)
s_wvalid  in  NUM_REQ  per-requester W valid
s_wready  out  NUM_REQ  per-requester W ready
s_bresp  out  NUM_REQ*2  per-requester BRESP
s_bvalid  out  NUM_REQ  per-requester B valid
s_bready  in  NUM_REQ  per-requester B ready
m_awid/m_awaddr/m_awuser  out  12/64/6  master AW payload
m_awvalid  out  1  master AW valid; m_awready in 1
m_wdata/m_wstrb/m_wlast  out  512/64/1  master W payload
m_wvalid  out  1  master W valid; m_wready in 1
m_bid/m_bresp/m_buser  in  12/2/4  master B payload (m_bid, m_buser unused)
m_bvalid  in  1  master B valid; m_bready out 1
grant_idx  out  IDX_W  currently or last granted requester
busy  out  1  high when state != IDLE
done_cnt  out  NUM_REQ*CNT_W  per-requester completed-write counters

Behaviour:
- Reset (checked every cycle, overrides all): state=IDLE, aw_done=w_done=0, last_grant=NUM_REQ-1 (requester 0 wins first), grant_idx=0, done_cnt=0. All m_*valid, m_bready, s_*ready and s_bvalid are 0 while in IDLE.
- Reset mid-transaction: the in-flight write is abandoned with no B forwarding. Any late m_bvalid arriving in IDLE is not accepted (m_bready=0).
- A request from requester i is pending when s_awvalid[i]=1. Requesters present AW and W together; arbitration keys only on AW.
- IDLE: if any request is pending, pick the first pending index scanning last_grant+1, +2, ... modulo NUM_REQ. Register it into grant_idx and go to ADDR_DATA on the next cycle. Arbitration takes 1 cycle; no master valid is driven in the grant cycle.
- ADDR_DATA: master AW/W payloads are a combinational mux of the granted requester's payload.
  - m_awvalid = s_awvalid[g] & ~aw_done
  - s_awready[g] = m_awready & ~aw_done
  - m_wvalid = s_wvalid[g] & ~w_done
  - s_wready[g] = m_wready & ~w_done
  - Set aw_done on the AW handshake and w_done on the W handshake; each may occur in any order or in the same cycle.
  - Go to RESP in the cycle after both are done, or in the same-cycle transition when the final handshake(s) happen this cycle (next state evaluated with post-handshake flags).
  - Non-granted readies are 0.
- RESP: s_bvalid[g]=m_bvalid, s_bresp[g]=m_bresp, m_bready=s_bready[g]. On the B handshake:
  - done_cnt[g]++, wraps at 2^CNT_W
  - last_grant=g, aw_done=w_done=0, state=IDLE
- Minimum period: 1 grant + 1 AW/W + 1 B = 3 cycles per write with always-ready slave.
- Fairness: with all requesters continuously pending, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- A requester dropping s_awvalid before grant is simply not chosen. Dropping it after grant is an AXI protocol violation and is not handled.
- busy = (state != IDLE). grant_idx holds its value in IDLE.
- The FSM has no default branch other than returning to IDLE.

Test Plan:
- Single request: requester 1 raises AW+W (addr 0x1000_0000), slave always ready, bvalid 1 cycle after W → m_awaddr=0x1000_0000 on cycle 2, s_bvalid[1] pulses once, done_cnt[1]=1, done_cnt[0]=0, back to IDLE.
- Round-robin: both requesters hold 6 back-to-back writes each → grant order 0,1,0,1,...; done_cnt={6,6}; no two master AW handshakes without an intervening B.
- Split handshakes: m_awready held low 3 cycles while m_wready=1 → W accepted first, w_done set, s_wready[g] deasserts, AW later accepted, exactly one W beat on master.
- B backpressure: s_bready[g]=0 for 4 cycles with m_bvalid=1 → m_bready=0, state stays RESP, counter unchanged until s_bready rises, then +1.
- Reset mid-operation: assert axi4_mm_rst in ADDR_DATA after the AW handshake → next cycle all valids/readies 0, done_cnt=0, next grant goes to requester 0.
- Counter wrap (CNT_W=4): 17 writes from requester 0 → done_cnt[0]=1.
